bp_io_link_to_lce_tracked: RTL and testbench

Registered, multi-outstanding bridge from the I/O memory-command link to the LCE request/command interface. It is the parametrised successor of the single-beat combinational I/O-to-LCE converter. It converts uncached I/O commands into LCE block requests and tracks up to `max_outstanding_p` in-flight requests in a metadata FIFO. It reconstructs each I/O response from the tracked metadata and flags protocol violations. It sits between the I/O link endpoint and the coherence network injection point of an I/O tile.

---
 rtl/bp_io_link_to_lce_tracked.sv | 241 ++++++++++++++++++++++++
 tb/tb_bp_io_link_to_lce_tracked.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_io_link_to_lce_tracked.sv
// ---------------------------------------------------------------------------
// bp_io_link_to_lce_tracked
//
// Registered bridge from the I/O memory-command link to the LCE uncached
// request/command interface. It can have up to max_outstanding_p requests in
// flight. Each accepted I/O command becomes an LCE block request. Its
// {addr, size, wr} metadata is pushed into an in-order tracking FIFO. Each
// LCE uncached completion pops that FIFO and is turned back into an I/O
// response. err_o latches any protocol violation until reset:
//   - a completion arrives with nothing tracked, or
//   - the completion's type or address disagrees with the FIFO head.
//
// Ports
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   lce_id_i                    source LCE id stamped into requests
//   io_cmd_i/_v_i/_yumi_o       I/O command in (valid/yumi)
//   io_resp_o/_v_o/_ready_i     I/O response out (valid/ready)
//   lce_req_o/_v_o/_ready_i     LCE request out (valid/ready)
//   lce_cmd_i/_v_i/_yumi_o      LCE uncached completion in (valid/yumi)
//   outstanding_o               number of tracked in-flight requests
//   err_o                       sticky protocol-error flag
//
// Message layouts (MSB first)
//   I/O mem msg : msg_type[3:0] | addr | size[2:0] | data
//   LCE request : dst_id | src_id | msg_type[2:0] | non_exclusive | addr |
//                 lru_way_id | lru_dirty | size[2:0] | data
//   LCE command : dst_id | msg_type[3:0] | way_id | addr | data
//
// Home CCE mapping: CCEs are interleaved on 64-byte blocks, so the home CCE
// is addr[7:6] (4 CCEs), zero-extended to the CCE id width.
// ---------------------------------------------------------------------------
module bp_io_link_to_lce_tracked #(
    // 0 selects the inverted-test I/O configuration (64-bit blocks).
    // Any other value selects 512-bit blocks.
    parameter int  bp_params_p       = 0,
    parameter int  max_outstanding_p = 4,

    localparam int paddr_width_p     = 40,
    localparam int lce_id_width_p    = 4,
    localparam int cce_id_width_p    = 4,
    localparam int cce_block_width_p = (bp_params_p == 0) ? 64 : 512,
    localparam int lce_assoc_p       = 8,
    localparam int lg_assoc_lp       = $clog2(lce_assoc_p),
    localparam int cnt_width_lp      = $clog2(max_outstanding_p + 1),

    localparam int cce_mem_msg_width_lp       = 4 + paddr_width_p + 3 + cce_block_width_p,
    localparam int lce_cce_block_req_width_lp = cce_id_width_p + lce_id_width_p + 3 + 1
                                                + paddr_width_p + lg_assoc_lp + 1 + 3
                                                + cce_block_width_p,
    localparam int lce_cmd_width_lp           = lce_id_width_p + 4 + lg_assoc_lp
                                                + paddr_width_p + cce_block_width_p
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [lce_id_width_p-1:0]             lce_id_i,

    input  logic [cce_mem_msg_width_lp-1:0]       io_cmd_i,
    input  logic                                  io_cmd_v_i,
    output logic                                  io_cmd_yumi_o,

    output logic [cce_mem_msg_width_lp-1:0]       io_resp_o,
    output logic                                  io_resp_v_o,
    input  logic                                  io_resp_ready_i,

    output logic [lce_cce_block_req_width_lp-1:0] lce_req_o,
    output logic                                  lce_req_v_o,
    input  logic                                  lce_req_ready_i,

    input  logic [lce_cmd_width_lp-1:0]           lce_cmd_i,
    input  logic                                  lce_cmd_v_i,
    output logic                                  lce_cmd_yumi_o,

    output logic [cnt_width_lp-1:0]               outstanding_o,
    output logic                                  err_o
);

    // Message type encodings
    localparam logic [3:0] e_cce_mem_uc_rd       = 4'h2;
    localparam logic [3:0] e_cce_mem_uc_wr       = 4'h3;
    localparam logic [2:0] e_lce_req_type_uc_rd  = 3'h2;
    localparam logic [2:0] e_lce_req_type_uc_wr  = 3'h3;
    localparam logic [3:0] e_lce_cmd_uc_st_done  = 4'h8;

    localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

    typedef struct packed {
        logic [3:0]                   msg_type;
        logic [paddr_width_p-1:0]     addr;
        logic [2:0]                   size;
        logic [cce_block_width_p-1:0] data;
    } mem_msg_t;

    typedef struct packed {
        logic [cce_id_width_p-1:0]    dst_id;
        logic [lce_id_width_p-1:0]    src_id;
        logic [2:0]                   msg_type;
        logic                         non_exclusive;
        logic [paddr_width_p-1:0]     addr;
        logic [lg_assoc_lp-1:0]       lru_way_id;
        logic                         lru_dirty;
        logic [2:0]                   size;
        logic [cce_block_width_p-1:0] data;
    } lce_req_t;

    typedef struct packed {
        logic [lce_id_width_p-1:0]    dst_id;
        logic [3:0]                   msg_type;
        logic [lg_assoc_lp-1:0]       way_id;
        logic [paddr_width_p-1:0]     addr;
        logic [cce_block_width_p-1:0] data;
    } lce_cmd_t;

    typedef struct packed {
        logic [paddr_width_p-1:0] addr;
        logic [2:0]               size;
        logic                     wr;
    } trk_t;

    function automatic logic [cce_id_width_p-1:0] addr_to_cce_id(input logic [paddr_width_p-1:0] addr);
        return cce_id_width_p'(addr[7:6]);
    endfunction

    mem_msg_t io_cmd;
    lce_cmd_t lce_cmd;
    assign io_cmd  = io_cmd_i;
    assign lce_cmd = lce_cmd_i;

    // State
    lce_req_t                 req_q, req_d;
    logic                     req_v_q, req_v_d;
    mem_msg_t                 resp_q, resp_d;
    logic                     resp_v_q, resp_v_d;
    logic [cnt_width_lp-1:0]  outstanding_q, outstanding_d;
    logic                     err_q, err_d;
    logic [ptr_width_lp-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    trk_t                     trk_mem [max_outstanding_p];

    logic io_yumi, cmd_yumi, fifo_empty, pop, cmd_wr;
    trk_t head, push_entry;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    always_comb begin
        // The credit check uses the registered count only, so a slot freed by a pop
        // in this cycle can only be reused from the next cycle.
        io_yumi    = io_cmd_v_i & (outstanding_q < cnt_width_lp'(max_outstanding_p))
                     & (~req_v_q | lce_req_ready_i);
        cmd_yumi   = lce_cmd_v_i & (~resp_v_q | io_resp_ready_i);
        // The tracking FIFO holds exactly the outstanding requests.
        fifo_empty = (outstanding_q == '0);
        pop        = cmd_yumi & ~fifo_empty;
        head       = trk_mem[rd_ptr_q];
        cmd_wr     = (lce_cmd.msg_type == e_lce_cmd_uc_st_done);

        push_entry.addr = io_cmd.addr;
        push_entry.size = io_cmd.size;
        push_entry.wr   = (io_cmd.msg_type == e_cce_mem_uc_wr);

        // Request register
        req_d = req_q;
        if (io_yumi) begin
            req_d          = '0;
            req_d.msg_type = push_entry.wr ? e_lce_req_type_uc_wr : e_lce_req_type_uc_rd;
            req_d.addr     = io_cmd.addr;
            req_d.size     = io_cmd.size;
            req_d.data     = io_cmd.data;
            req_d.src_id   = lce_id_i;
            req_d.dst_id   = addr_to_cce_id(io_cmd.addr);
        end
        req_v_d = io_yumi | (req_v_q & ~lce_req_ready_i);

        // Response register: metadata always comes from the FIFO head.
        resp_d = resp_q;
        if (pop) begin
            resp_d.msg_type = head.wr ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
            resp_d.addr     = head.addr;
            resp_d.size     = head.size;
            resp_d.data     = lce_cmd.data;
        end
        resp_v_d = pop | (resp_v_q & ~io_resp_ready_i);

        err_d = err_q
              | (cmd_yumi & fifo_empty)
              | (pop & ((cmd_wr != head.wr) | (lce_cmd.addr != head.addr)));

        outstanding_d = outstanding_q;
        case ({io_yumi, pop})
            2'b10:   outstanding_d = outstanding_q + cnt_width_lp'(1);
            2'b01:   outstanding_d = outstanding_q - cnt_width_lp'(1);
            default: outstanding_d = outstanding_q;
        endcase

        wr_ptr_d = io_yumi ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop     ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    // Control state: asynchronous reset discards everything in flight.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_v_q       <= 1'b0;
            resp_v_q      <= 1'b0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            req_v_q       <= req_v_d;
            resp_v_q      <= resp_v_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Payload registers and tracking storage need no reset.
    // They are qualified by the valid bits and pointers above.
    always_ff @(posedge clk_i) begin
        req_q  <= req_d;
        resp_q <= resp_d;
        if (io_yumi) begin
            trk_mem[wr_ptr_q] <= push_entry;
        end
    end

    // The completion's routing fields carry no information for this bridge.
    logic unused_cmd_fields;
    assign unused_cmd_fields = ^{lce_cmd.dst_id, lce_cmd.way_id};

    assign io_cmd_yumi_o  = io_yumi;
    assign lce_cmd_yumi_o = cmd_yumi;
    assign lce_req_o      = req_q;
    assign lce_req_v_o    = req_v_q;
    assign io_resp_o      = resp_q;
    assign io_resp_v_o    = resp_v_q;
    assign outstanding_o  = outstanding_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_bp_io_link_to_lce_tracked.sv
// ---------------------------------------------------------------------------
// Directed bench for bp_io_link_to_lce_tracked (default configuration:
// 40-bit addresses, 64-bit data, 4 outstanding).
// Inputs change 1 ns after a rising edge. Outputs are sampled 1-2 ns after it.
// ---------------------------------------------------------------------------
module tb_bp_io_link_to_lce_tracked;

    localparam logic [3:0] MEM_UC_RD  = 4'h2;
    localparam logic [3:0] MEM_UC_WR  = 4'h3;
    localparam logic [3:0] CMD_UC_DAT = 4'h7;
    localparam logic [3:0] CMD_ST_DON = 4'h8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   lce_id = 4'h5;
    logic [110:0] io_cmd = '0;
    logic         io_cmd_v = 1'b0;
    logic         io_cmd_yumi;
    logic [110:0] io_resp;
    logic         io_resp_v;
    logic         io_resp_ready = 1'b1;
    logic [122:0] lce_req;
    logic         lce_req_v;
    logic         lce_req_ready = 1'b1;
    logic [114:0] lce_cmd = '0;
    logic         lce_cmd_v = 1'b0;
    logic         lce_cmd_yumi;
    logic [2:0]   outstanding;
    logic         err;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    bp_io_link_to_lce_tracked dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .lce_id_i        (lce_id),
        .io_cmd_i        (io_cmd),
        .io_cmd_v_i      (io_cmd_v),
        .io_cmd_yumi_o   (io_cmd_yumi),
        .io_resp_o       (io_resp),
        .io_resp_v_o     (io_resp_v),
        .io_resp_ready_i (io_resp_ready),
        .lce_req_o       (lce_req),
        .lce_req_v_o     (lce_req_v),
        .lce_req_ready_i (lce_req_ready),
        .lce_cmd_i       (lce_cmd),
        .lce_cmd_v_i     (lce_cmd_v),
        .lce_cmd_yumi_o  (lce_cmd_yumi),
        .outstanding_o   (outstanding),
        .err_o           (err)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [110:0] mk_io(input logic [3:0] t, input logic [39:0] a,
                                           input logic [2:0] s, input logic [63:0] d);
        return {t, a, s, d};
    endfunction

    // dst_id and way_id are filled with junk the bridge must ignore.
    function automatic logic [114:0] mk_cmd(input logic [3:0] t, input logic [39:0] a,
                                            input logic [63:0] d);
        return {4'hA, t, 3'd2, a, d};
    endfunction

    logic [122:0] snap;
    int           yumis;
    int           k;

    initial begin
        // ---------------- reset ----------------
        tick(); tick();
        chk("rst_req_v", lce_req_v, 0);
        chk("rst_resp_v", io_resp_v, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err, 0);
        reset_n = 1'b1;
        tick();

        // ---------------- single read ----------------
        io_cmd = mk_io(MEM_UC_RD, 40'h00_8000_0040, 3'd3, 64'h0);
        io_cmd_v = 1'b1;
        #1 chk("rd_yumi", io_cmd_yumi, 1);
        tick();
        io_cmd_v = 1'b0;
        chk("rd_req_v", lce_req_v, 1);
        chk("rd_req_type", lce_req[114:112], 3'h2);
        chk("rd_req_src", lce_req[118:115], 4'h5);
        chk("rd_req_dst", lce_req[122:119], 4'h1);
        chk("rd_req_addr", lce_req[110:71], 40'h00_8000_0040);
        chk("rd_req_size", lce_req[66:64], 3'd3);
        chk("rd_req_zero", {lce_req[111], lce_req[70:67]}, 0);
        chk("rd_outstanding", outstanding, 1);
        tick();
        chk("rd_req_drained", lce_req_v, 0);
        lce_cmd = mk_cmd(CMD_UC_DAT, 40'h00_8000_0040, 64'h1122_3344_5566_7788);
        lce_cmd_v = 1'b1;
        #1 chk("rd_cmd_yumi", lce_cmd_yumi, 1);
        tick();
        lce_cmd_v = 1'b0;
        chk("rd_resp_v", io_resp_v, 1);
        chk("rd_resp_type", io_resp[110:107], MEM_UC_RD);
        chk("rd_resp_addr", io_resp[106:67], 40'h00_8000_0040);
        chk("rd_resp_size", io_resp[66:64], 3'd3);
        chk("rd_resp_data", io_resp[63:0], 64'h1122_3344_5566_7788);
        chk("rd_outstanding0", outstanding, 0);
        chk("rd_err", err, 0);
        tick();
        chk("rd_resp_drained", io_resp_v, 0);

        // ---------------- credit limit: 6 writes offered ----------------
        yumis = 0;
        k = 0;
        io_cmd_v = 1'b1;
        for (int c = 0; c < 6; c++) begin
            io_cmd = mk_io(MEM_UC_WR, 40'h1000 + 40'(64 * k), 3'd3, 64'(k));
            #1;
            if (io_cmd_yumi) begin
                yumis++;
                k++;
            end
            tick();
            if (c == 0) chk("wr_req_type", lce_req[114:112], 3'h3);
        end
        chk("credit_yumis", yumis, 4);
        chk("credit_outstanding", outstanding, 4);
        io_cmd = mk_io(MEM_UC_WR, 40'h1000 + 40'(64 * k), 3'd3, 64'(k));
        #1 chk("credit_full_yumi", io_cmd_yumi, 0);
        lce_cmd = mk_cmd(CMD_ST_DON, 40'h1000, 64'h0);
        lce_cmd_v = 1'b1;
        #1;
        chk("credit_pop_yumi", lce_cmd_yumi, 1);
        chk("credit_no_bypass", io_cmd_yumi, 0);
        tick();
        lce_cmd_v = 1'b0;
        chk("credit_resp_type", io_resp[110:107], MEM_UC_WR);
        chk("credit_resp_addr", io_resp[106:67], 40'h1000);
        chk("credit_after_pop", outstanding, 3);
        #1 chk("credit_next_cycle", io_cmd_yumi, 1);
        tick();
        io_cmd_v = 1'b0;
        chk("credit_refill", outstanding, 4);
        for (int i = 1; i <= 4; i++) begin
            lce_cmd = mk_cmd(CMD_ST_DON, 40'h1000 + 40'(64 * i), 64'h0);
            lce_cmd_v = 1'b1;
            tick();
            chk("drain_addr", io_resp[106:67], 40'h1000 + 40'(64 * i));
        end
        lce_cmd_v = 1'b0;
        chk("drain_outstanding", outstanding, 0);
        chk("drain_err", err, 0);

        // ---------------- request backpressure ----------------
        lce_req_ready = 1'b0;
        io_cmd = mk_io(MEM_UC_RD, 40'h2000, 3'd3, 64'h0);
        io_cmd_v = 1'b1;
        #1 chk("bp_first_yumi", io_cmd_yumi, 1);
        tick();
        snap = lce_req;
        io_cmd = mk_io(MEM_UC_RD, 40'h2040, 3'd3, 64'h0);
        for (int c = 0; c < 5; c++) begin
            #1 chk("bp_yumi_held", io_cmd_yumi, 0);
            tick();
            chk("bp_req_stable", lce_req, snap);
        end
        lce_req_ready = 1'b1;
        #1 chk("bp_release_yumi", io_cmd_yumi, 1);
        tick();
        io_cmd_v = 1'b0;
        chk("bp_req_next", lce_req[110:71], 40'h2040);
        tick();

        // ---------------- response backpressure ----------------
        io_resp_ready = 1'b0;
        lce_cmd = mk_cmd(CMD_UC_DAT, 40'h2000, 64'hAA);
        lce_cmd_v = 1'b1;
        #1 chk("rbp_first_yumi", lce_cmd_yumi, 1);
        tick();
        chk("rbp_resp_v", io_resp_v, 1);
        lce_cmd = mk_cmd(CMD_UC_DAT, 40'h2040, 64'hBB);
        for (int c = 0; c < 2; c++) begin
            #1 chk("rbp_cmd_yumi_held", lce_cmd_yumi, 0);
            tick();
            chk("rbp_resp_held", io_resp[106:67], 40'h2000);
        end
        io_resp_ready = 1'b1;
        #1 chk("rbp_release_yumi", lce_cmd_yumi, 1);
        tick();
        lce_cmd_v = 1'b0;
        chk("rbp_resp_addr", io_resp[106:67], 40'h2040);
        chk("rbp_resp_data", io_resp[63:0], 64'hBB);
        chk("rbp_outstanding", outstanding, 0);

        // ---------------- simultaneous accept and pop ----------------
        io_cmd = mk_io(MEM_UC_RD, 40'h3000, 3'd2, 64'h0);
        io_cmd_v = 1'b1;
        tick();
        io_cmd = mk_io(MEM_UC_RD, 40'h3040, 3'd2, 64'h0);
        tick();
        chk("sim_outstanding2", outstanding, 2);
        io_cmd = mk_io(MEM_UC_RD, 40'h3080, 3'd2, 64'h0);
        lce_cmd = mk_cmd(CMD_UC_DAT, 40'h3000, 64'h1);
        lce_cmd_v = 1'b1;
        #1;
        chk("sim_io_yumi", io_cmd_yumi, 1);
        chk("sim_cmd_yumi", lce_cmd_yumi, 1);
        tick();
        io_cmd_v = 1'b0;
        chk("sim_outstanding_hold", outstanding, 2);
        chk("sim_resp0", io_resp[106:67], 40'h3000);
        lce_cmd = mk_cmd(CMD_UC_DAT, 40'h3040, 64'h2);
        tick();
        chk("sim_resp1", io_resp[106:67], 40'h3040);
        lce_cmd = mk_cmd(CMD_UC_DAT, 40'h3080, 64'h3);
        tick();
        lce_cmd_v = 1'b0;
        chk("sim_resp2", io_resp[106:67], 40'h3080);
        chk("sim_resp2_size", io_resp[66:64], 3'd2);
        chk("sim_outstanding0", outstanding, 0);
        chk("sim_err", err, 0);

        // ---------------- type mismatch ----------------
        io_cmd = mk_io(MEM_UC_RD, 40'h4000, 3'd3, 64'h0);
        io_cmd_v = 1'b1;
        tick();
        io_cmd_v = 1'b0;
        lce_cmd = mk_cmd(CMD_ST_DON, 40'h4000, 64'h0);
        lce_cmd_v = 1'b1;
        #1 chk("mm_err_before", err, 0);
        tick();
        lce_cmd_v = 1'b0;
        chk("mm_resp_v", io_resp_v, 1);
        chk("mm_resp_type", io_resp[110:107], MEM_UC_RD);
        chk("mm_resp_addr", io_resp[106:67], 40'h4000);
        chk("mm_err", err, 1);

        // ---------------- async reset with 3 outstanding ----------------
        io_cmd_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            io_cmd = mk_io(MEM_UC_RD, 40'h5000 + 40'(64 * i), 3'd3, 64'h0);
            tick();
        end
        io_cmd_v = 1'b0;
        chk("ar_outstanding3", outstanding, 3);
        chk("ar_req_v_before", lce_req_v, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_req_v", lce_req_v, 0);
        chk("ar_resp_v", io_resp_v, 0);
        chk("ar_outstanding", outstanding, 0);
        chk("ar_err", err, 0);
        chk("ar_io_yumi", io_cmd_yumi, 0);
        chk("ar_cmd_yumi", lce_cmd_yumi, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // ---------------- completion with empty FIFO ----------------
        lce_cmd = mk_cmd(CMD_UC_DAT, 40'h6000, 64'h0);
        lce_cmd_v = 1'b1;
        #1 chk("empty_cmd_yumi", lce_cmd_yumi, 1);
        tick();
        lce_cmd_v = 1'b0;
        chk("empty_resp_v", io_resp_v, 0);
        chk("empty_err", err, 1);
        chk("empty_outstanding", outstanding, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
